snail_pattern_ctrl: RTL and testbench
=====================================

Name: snail_pattern_ctrl

Overview:
Controller that sequences a bit-serial pattern-detection run over a bounded window of input bits. It latches a configurable PAT_W-bit pattern (default 3'b101) and a window length on start. It accepts bits through a valid/ready handshake and counts every overlapping match. It reports per-match pulses, a final count and a done pulse. It sits between a bit source (test stimulus or shift-out logic) and status/readout logic in the lab-work designs.

Parameters:
PAT_W, 3, pattern length in bits (>=2)
WIN_W, 8, width of window-length field and consumed-bit counter
CNT_W, 8, width of match counter

Ports:
clk  input  1  system clock, all state on posedge
_rst  input  1  asynchronous active-low reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  terminate run; sampled only in RUN
pattern  input  PAT_W  pattern to detect; first-received bit is MSB; latched on accepted start
win_len  input  WIN_W  number of bits to scan; latched on accepted start
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in valid
bit_ready  output  1  controller accepts a bit this cycle
match  output  1  one-cycle pulse per detected pattern occurrence
match_cnt  output  CNT_W  matches in current/last run
busy  output  1  high in RUN
done  output  1  one-cycle pulse at normal run completion
overflow  output  1  sticky: match_cnt saturated during run

Behaviour:
- Reset (_rst low, asynchronous): state=IDLE. bit_ready, match, busy, done, overflow = 0. match_cnt=0. Shift register, fill counter and consumed counter = 0.
- States: IDLE=0, RUN=1, DONE=2. Encoding 3 is illegal; go to IDLE.
- All outputs are registered or decoded from state only (Moore). No combinational path from inputs to outputs.
- IDLE: bit_ready=0, busy=0.
  - start=1 and win_len!=0: latch pattern and win_len; clear shift reg, fill, consumed, match_cnt, overflow; next=RUN.
  - start=1 and win_len==0: clear match_cnt and overflow; next=DONE (zero-length run).
- RUN: busy=1, bit_ready=1. A bit is accepted on a posedge with bit_valid=1.
  - On acceptance: shift reg <= {shift[PAT_W-2:0], bit_in}. fill increments, saturating at PAT_W. consumed increments.
  - Match condition is evaluated on the post-shift value: fill (after update) == PAT_W and shift == pattern.
  - On a match: match=1 for exactly the following cycle. match_cnt++ saturating at 2^CNT_W-1. overflow=1 if a match occurs while already saturated.
  - Overlapping matches count. 10101 against 101 gives 2 matches.
  - When the accepted bit makes consumed==win_len: next=DONE. bit_ready drops the next cycle.
  - bit_valid=0: no state change. Stalls of any length are allowed.
  - abort=1: next=IDLE. No done pulse. match_cnt and overflow hold their values. abort has priority over bit acceptance in the same cycle; that bit is not consumed.
- DONE: done=1 for one cycle, busy=0, bit_ready=0; next=IDLE. A match pulse from the last bit coincides with done.
- start outside IDLE is ignored. abort outside RUN is ignored. pattern and win_len changes after latching have no effect.
- Reset mid-run: immediate return to reset values, no done pulse.
- Latency: bit accepted at edge N, match visible in cycle N+1. Start at edge S, bit_ready=1 in cycle S+1.

Decomposition:
- Shared package snail_pkg: state localparams (IDLE, RUN, DONE), default PAT_W/WIN_W/CNT_W constants, default pattern 3'b101.
- Sub-module snail_shift_cmp: shift register, fill counter and equality compare. Ports: clk, _rst, clr, shift_en, bit_in, pattern; output hit (combinational).
- The controller holds the FSM, consumed counter, match counter and output registers.

Test Plan:
1. Reset: assert _rst=0 mid-run, then release. All outputs 0, state IDLE, match_cnt=0. Next start works normally.
2. pattern=101, win_len=8, bits 1,0,1,0,1,1,0,1 with bit_valid always high. match pulses after bits 3, 5 and 8. match_cnt=3. done pulse coincides with the third match. busy high for exactly 8 cycles.
3. Same stream with bit_valid low for 2 cycles between each bit. Same match_cnt=3, no extra or lost bits, bit_ready held high throughout RUN.
4. win_len=0. start gives done one cycle later, match_cnt=0, bit_ready never asserts.
5. pattern=111, win_len=4, bits 1,1,0,1. The two leading 1s do not match before fill=3. match_cnt=0, done pulse.
6. Two cases, separate runs:
   - CNT_W=2, pattern=11, win_len=6, all ones: match_cnt saturates at 3 and overflow=1.
   - abort after bit 4 of a run: busy falls, no done, match_cnt holds.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared definitions for the serial pattern-detection controller:
// state encoding and default geometry.
package snail_pkg;

  localparam int PAT_W_DEF = 3;
  localparam int WIN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/snail_shift_cmp.sv
// Bit history shift register with fill tracking. Reports whether the bit
// being shifted in this cycle completes an occurrence of the pattern.
module snail_shift_cmp
  import snail_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  shift_q, shift_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // hit looks at the post-shift view so the match can be registered on
  // the same edge that accepts the bit.
  always_comb begin
    shift_d = {shift_q[PAT_W-2:0], bit_in};
    fill_d  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hit     = shift_en && (fill_d == FILL_W'(PAT_W)) && (shift_d == pattern);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else if (clr) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else if (shift_en) begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/snail_pattern_ctrl.sv
// Run controller: latches pattern/window on start, consumes bits through a
// valid/ready handshake, counts overlapping matches and signals completion.
module snail_pattern_ctrl
  import snail_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [WIN_W-1:0] win_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_e state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] consumed_q, consumed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;

  logic start_ok;
  logic accept;
  logic last_bit;
  logic hit;

  // abort wins over a bit offered in the same cycle.
  assign start_ok = (state_q == IDLE) && start;
  assign accept   = (state_q == RUN) && bit_valid && !abort;
  assign last_bit = accept && ((consumed_q + WIN_W'(1)) == win_q);

  snail_shift_cmp #(
    .PAT_W(PAT_W)
  ) u_shift_cmp (
    .clk      (clk),
    ._rst     (_rst),
    .clr      (start_ok),
    .shift_en (accept),
    .bit_in   (bit_in),
    .pattern  (pat_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (win_len != '0) ? RUN : DONE;
      RUN:     if (abort) state_d = IDLE;
               else if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    bit_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      RUN: begin
        busy      = 1'b1;
        bit_ready = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pat_d      = pat_q;
    win_d      = win_q;
    consumed_d = consumed_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    match_d    = hit;
    if (start_ok) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      if (win_len != '0) begin
        pat_d      = pattern;
        win_d      = win_len;
        consumed_d = '0;
      end
    end else if (accept) begin
      consumed_d = consumed_q + WIN_W'(1);
      if (hit) begin
        if (cnt_q == '1) ovf_d = 1'b1;
        else             cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      pat_q      <= '0;
      win_q      <= '0;
      consumed_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      win_q      <= win_d;
      consumed_q <= consumed_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_snail_pattern_ctrl.sv
// Self-checking bench: directed and randomized runs on a default instance
// and a narrow (PAT_W=2, CNT_W=2) instance, against a bit-history model.
module tb_snail_pattern_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_start, a_abort, a_bit_in, a_bit_valid;
  logic [2:0] a_pattern;
  logic [7:0] a_win_len;
  logic       a_bit_ready, a_match, a_busy, a_done, a_overflow;
  logic [7:0] a_match_cnt;

  logic       b_start, b_abort, b_bit_in, b_bit_valid;
  logic [1:0] b_pattern;
  logic [7:0] b_win_len;
  logic       b_bit_ready, b_match, b_busy, b_done, b_overflow;
  logic [1:0] b_match_cnt;

  int checks   = 0;
  int failures = 0;

  snail_pattern_ctrl u_dut_a (
    .clk       (clk),
    ._rst      (rst_n),
    .start     (a_start),
    .abort     (a_abort),
    .pattern   (a_pattern),
    .win_len   (a_win_len),
    .bit_in    (a_bit_in),
    .bit_valid (a_bit_valid),
    .bit_ready (a_bit_ready),
    .match     (a_match),
    .match_cnt (a_match_cnt),
    .busy      (a_busy),
    .done      (a_done),
    .overflow  (a_overflow)
  );

  snail_pattern_ctrl #(.PAT_W(2), .WIN_W(8), .CNT_W(2)) u_dut_b (
    .clk       (clk),
    ._rst      (rst_n),
    .start     (b_start),
    .abort     (b_abort),
    .pattern   (b_pattern),
    .win_len   (b_win_len),
    .bit_in    (b_bit_in),
    .bit_valid (b_bit_valid),
    .bit_ready (b_bit_ready),
    .match     (b_match),
    .match_cnt (b_match_cnt),
    .busy      (b_busy),
    .done      (b_done),
    .overflow  (b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic ab, input logic [2:0] pat,
                       input logic [7:0] wl, input logic bi, input logic bv);
    if (sel == 0) begin
      a_start = st; a_abort = ab; a_pattern = pat; a_win_len = wl;
      a_bit_in = bi; a_bit_valid = bv;
    end else begin
      b_start = st; b_abort = ab; b_pattern = pat[1:0]; b_win_len = wl;
      b_bit_in = bi; b_bit_valid = bv;
    end
  endtask

  task automatic check_outs(input int sel, input string tag, input logic e_rdy, input logic e_m,
                            input logic e_bs, input logic e_dn, input logic e_ov, input int e_cnt);
    logic       rdy, m, bs, dn, ov;
    logic [7:0] cnt;
    if (sel == 0) begin
      rdy = a_bit_ready; m = a_match; bs = a_busy; dn = a_done; ov = a_overflow; cnt = a_match_cnt;
    end else begin
      rdy = b_bit_ready; m = b_match; bs = b_busy; dn = b_done; ov = b_overflow;
      cnt = {6'b0, b_match_cnt};
    end
    check($sformatf("%s.bit_ready", tag), 32'(rdy), 32'(e_rdy));
    check($sformatf("%s.match", tag),     32'(m),   32'(e_m));
    check($sformatf("%s.busy", tag),      32'(bs),  32'(e_bs));
    check($sformatf("%s.done", tag),      32'(dn),  32'(e_dn));
    check($sformatf("%s.overflow", tag),  32'(ov),  32'(e_ov));
    check($sformatf("%s.match_cnt", tag), 32'(cnt), 32'(e_cnt));
  endtask

  // True when the most recent pw received bits, oldest first, spell the pattern MSB first.
  function automatic bit matched(input bit q[$], input logic [2:0] pat, input int pw);
    if (q.size() < pw) return 1'b0;
    for (int i = 0; i < pw; i++)
      if (q[q.size() - pw + i] != pat[pw - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  // One complete run: bits[k] is the k-th bit sent. Inputs other than the
  // handshake are scrambled while running to show they are ignored.
  task automatic run(input int sel, input int pw, input logic [2:0] pat, input int wlen,
                     input logic [255:0] bits, input int stall_fix, input int stall_rnd,
                     input string tag);
    bit   q[$];
    int   cnt  = 0;
    logic ovf  = 1'b0;
    int   maxc = (sel == 0) ? 255 : 3;
    int   ns;
    bit   m;
    drive(sel, 1'b1, 1'b0, pat, 8'(wlen), 1'b0, 1'b0);
    step();
    check_outs(sel, {tag, ".start"}, wlen != 0, 1'b0, wlen != 0, wlen == 0, 1'b0, 0);
    for (int k = 0; k < wlen; k++) begin
      ns = stall_fix + ((stall_rnd > 0) ? int'($urandom_range(stall_rnd, 0)) : 0);
      for (int s = 0; s < ns; s++) begin
        drive(sel, 1'($urandom_range(1, 0)), 1'b0, 3'($urandom), 8'($urandom),
              1'($urandom_range(1, 0)), 1'b0);
        step();
        check_outs(sel, {tag, ".stall"}, 1'b1, 1'b0, 1'b1, 1'b0, ovf, cnt);
      end
      drive(sel, 1'($urandom_range(1, 0)), 1'b0, 3'($urandom), 8'($urandom), bits[k], 1'b1);
      step();
      q.push_back(bits[k]);
      m = matched(q, pat, pw);
      if (m) begin
        if (cnt == maxc) ovf = 1'b1;
        else             cnt++;
      end
      check_outs(sel, $sformatf("%s.bit%0d", tag, k), k != wlen - 1, m, k != wlen - 1,
                 k == wlen - 1, ovf, cnt);
    end
    drive(sel, 1'b0, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0);
    step();
    check_outs(sel, {tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, ovf, cnt);
  endtask

  initial begin
    logic [255:0] rbits;
    logic [2:0]   rpat;
    int           rlen;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    check_outs(0, "reset_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_outs(1, "reset_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-run, right as a match pulse is showing.
    drive(0, 1'b1, 1'b0, 3'b101, 8'd8, 1'b0, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 3'b101, 8'd8, 1'b1, 1'b1); step();
    drive(0, 1'b0, 1'b0, 3'b101, 8'd8, 1'b0, 1'b1); step();
    drive(0, 1'b0, 1'b0, 3'b101, 8'd8, 1'b1, 1'b1); step();
    check_outs(0, "pre_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    drive(0, 1'b0, 1'b0, 3'b0, 8'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outs(0, "mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    rst_n = 1'b1;
    step();
    check_outs(0, "post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    run(0, 3, 3'b101, 8, 256'hB5, 0, 0, "p101_full");
    run(0, 3, 3'b101, 8, 256'hB5, 2, 0, "p101_stall");
    run(0, 3, 3'b101, 0, 256'h0, 0, 0, "zero_len");
    run(0, 3, 3'b111, 4, 256'hB, 0, 0, "p111_fill");
    run(1, 2, 3'b011, 6, 256'h3F, 0, 0, "sat_ovf");

    // Abort on the cycle a completing bit is offered: that bit must not count.
    drive(0, 1'b1, 1'b0, 3'b101, 8'd10, 1'b0, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b1, 1'b1); step();
    drive(0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 1'b1); step();
    drive(0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b1, 1'b1); step();
    drive(0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 1'b1); step();
    check_outs(0, "pre_abort", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(0, 1'b0, 1'b1, 3'b000, 8'd0, 1'b1, 1'b1);
    step();
    check_outs(0, "abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(0, 1'b0, 1'b1, 3'b000, 8'd0, 1'b0, 1'b0);
    step();
    check_outs(0, "post_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rbits = {8{$urandom}};
      rpat  = 3'($urandom);
      rlen  = int'($urandom_range(24, 1));
      run(0, 3, rpat, rlen, rbits, 0, 2, $sformatf("rand_a%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      rbits = {8{$urandom}};
      rpat  = {1'b0, 2'($urandom)};
      rlen  = int'($urandom_range(20, 5));
      run(1, 2, rpat, rlen, rbits, 0, 1, $sformatf("rand_b%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
